// File: rtl/proc_run_ctrl_if.sv
// Handshake and status bundle between the run controller and whoever launches runs.
// The slave side is the controller; the master side drives start/program data and the processor taps.
interface proc_run_ctrl_if #(
    parameter int DATA_W = 64
);
    logic              start;
    logic [DATA_W-1:0] start_pc;
    logic [DATA_W-1:0] end_pc;
    logic [DATA_W-1:0] expected;
    logic [DATA_W-1:0] currentpc;
    logic [DATA_W-1:0] memtoreg_out;
    logic              proc_reset;
    logic [DATA_W-1:0] proc_startpc;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [DATA_W-1:0] result;
    logic [15:0]       cycle_count;
    logic [7:0]        run_count;
    logic [7:0]        pass_count;
    logic              all_passed;

    modport master (
        output start, start_pc, end_pc, expected, currentpc, memtoreg_out,
        input  proc_reset, proc_startpc, busy, done, pass, timeout, result,
               cycle_count, run_count, pass_count, all_passed
    );

    modport slave (
        input  start, start_pc, end_pc, expected, currentpc, memtoreg_out,
        output proc_reset, proc_startpc, busy, done, pass, timeout, result,
               cycle_count, run_count, pass_count, all_passed
    );
endinterface

// File: rtl/proc_run_ctrl.sv
// Run controller for the single-cycle processor: holds it in reset, releases it, watches the PC
// for the end address (or the watchdog), then scores the captured result and keeps run tallies.
module proc_run_ctrl #(
    parameter int          DATA_W       = 64,
    parameter int          RESET_CYCLES = 2,
    parameter logic [15:0] WATCHDOG     = 16'h00FF
) (
    input  logic           CLK,
    input  logic           reset,
    proc_run_ctrl_if.slave bus
);

    localparam int HOLD_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [HOLD_W-1:0] hold_cnt;
    logic [DATA_W-1:0] start_pc_q;
    logic [DATA_W-1:0] end_pc_q;
    logic [DATA_W-1:0] expected_q;
    logic [DATA_W-1:0] result_q;
    logic [15:0]       cycle_count_q;
    logic [7:0]        run_count_q;
    logic [7:0]        pass_count_q;
    logic              pass_q;
    logic              timeout_q;
    logic              done_q;

    logic              accept;
    logic              end_hit;
    logic              wd_hit;
    logic              match;
    logic [15:0]       cycle_inc;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge CLK) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // End detection is tested first so it wins over the watchdog on the same edge.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        end_hit    = 1'b0;
        wd_hit     = 1'b0;
        cycle_inc  = sat_inc16(cycle_count_q);
        match      = (bus.memtoreg_out == expected_q);
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt <= HOLD_W'(1)) next_state = S_RUN;
            end
            S_RUN: begin
                if (bus.currentpc >= end_pc_q) begin
                    end_hit    = 1'b1;
                    next_state = S_DONE;
                end else if (cycle_inc == WATCHDOG) begin
                    wd_hit     = 1'b1;
                    next_state = S_DONE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            hold_cnt      <= '0;
            start_pc_q    <= '0;
            end_pc_q      <= '0;
            expected_q    <= '0;
            result_q      <= '0;
            cycle_count_q <= '0;
            run_count_q   <= '0;
            pass_count_q  <= '0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= end_hit | wd_hit;
            if (accept) begin
                start_pc_q    <= bus.start_pc;
                end_pc_q      <= bus.end_pc;
                expected_q    <= bus.expected;
                hold_cnt      <= HOLD_W'(RESET_CYCLES);
                cycle_count_q <= '0;
                pass_q        <= 1'b0;
                timeout_q     <= 1'b0;
                result_q      <= '0;
            end
            if (state == S_HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            if (state == S_RUN) begin
                cycle_count_q <= cycle_inc;
                if (end_hit) begin
                    result_q    <= bus.memtoreg_out;
                    pass_q      <= match;
                    timeout_q   <= 1'b0;
                    run_count_q <= run_count_q + 8'd1;
                    if (match) pass_count_q <= pass_count_q + 8'd1;
                end else if (wd_hit) begin
                    result_q    <= bus.memtoreg_out;
                    pass_q      <= 1'b0;
                    timeout_q   <= 1'b1;
                    run_count_q <= run_count_q + 8'd1;
                end
            end
        end
    end

    // The processor runs only in RUN; DONE freezes it back in reset.
    assign bus.proc_reset   = (state != S_RUN);
    assign bus.proc_startpc = start_pc_q;
    assign bus.busy         = (state == S_HOLD) || (state == S_RUN);
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.timeout      = timeout_q;
    assign bus.result       = result_q;
    assign bus.cycle_count  = cycle_count_q;
    assign bus.run_count    = run_count_q;
    assign bus.pass_count   = pass_count_q;
    assign bus.all_passed   = (pass_count_q == run_count_q) && (run_count_q != 8'd0);

endmodule
